// File: rtl/onehot_index_queue.sv
// One-hot to binary index converter feeding a small valid/ready FIFO; illegal vectors are dropped and flagged.
// Optional illegal-accept counter output err_cnt enabled by macro ONEHOT_INDEX_QUEUE_ERR_CNT_EN.
module onehot_index_queue #(
    parameter int N     = 4,
    parameter int IDX_W = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N-1:0]     in_onehot,
    output logic             in_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [IDX_W:0]   count,
    output logic             err,
    input  logic             err_clr
`ifdef ONEHOT_INDEX_QUEUE_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] FULL_C = (IDX_W+1)'(DEPTH);

    // A vector is legal when it is non-zero and clearing its lowest set bit leaves nothing.
    function automatic logic is_onehot(input logic [N-1:0] v);
        logic [N-1:0] low_cleared;
        low_cleared = v & (v - {{(N-1){1'b0}}, 1'b1});
        return (v != {N{1'b0}}) && (low_cleared == {N{1'b0}});
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                idx = i[IDX_W-1:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [IDX_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [IDX_W:0]   count_r;
    logic             err_r;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             accept_s;
    logic             legal_s;
    logic             push_s;
    logic             pop_s;
    logic             illegal_s;
    logic [IDX_W:0]   count_nxt_s;

    assign in_ready_s  = (count_r != FULL_C);
    assign out_valid_s = (count_r != {(IDX_W+1){1'b0}});
    assign legal_s     = is_onehot(in_onehot);
    assign accept_s    = in_valid & in_ready_s;
    assign push_s      = accept_s & legal_s;
    assign illegal_s   = accept_s & ~legal_s;
    assign pop_s       = out_valid_s & out_ready;

    // Occupancy next-state from the push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + {{IDX_W{1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{IDX_W{1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {IDX_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(IDX_W+1){1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= onehot_to_idx(in_onehot);
                wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            count_r <= count_nxt_s;
        end
    end

    // Sticky error flag; a new illegal accept beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (illegal_s) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end
    end

`ifdef ONEHOT_INDEX_QUEUE_ERR_CNT_EN
    logic [7:0] err_cnt_r;

    // Saturating illegal-accept counter; clear restarts it at the same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 8'd0;
        end else if (err_clr) begin
            err_cnt_r <= illegal_s ? 8'd1 : 8'd0;
        end else if (illegal_s && (err_cnt_r != 8'd255)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_idx   = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign err       = err_r;

endmodule

// File: tb/tb_onehot_index_queue.sv
// Directed bench for onehot_index_queue: a queue-based reference model checked every cycle plus literal expectations.
module tb_onehot_index_queue;

    localparam int N     = 4;
    localparam int IDX_W = 2;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [N-1:0]     in_onehot;
    logic             in_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_ready;
    logic [IDX_W:0]   count;
    logic             err;
    logic             err_clr;
`ifdef ONEHOT_INDEX_QUEUE_ERR_CNT_EN
    logic [7:0]       err_cnt;
`endif

    onehot_index_queue #(.N(N), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_onehot (in_onehot),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .count     (count),
        .err       (err),
        .err_clr   (err_clr)
`ifdef ONEHOT_INDEX_QUEUE_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Reference model state
    int m_q[$];
    bit m_err;
    int m_err_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_err     = 1'b0;
        m_err_cnt = 0;
    endtask

    // Apply one cycle of inputs from a falling edge, advance the model at the rising edge.
    task automatic step(input bit v, input logic [N-1:0] oh, input bit rdy, input bit clr);
        bit acc;
        bit legal;
        int idx;
        in_valid  = v;
        in_onehot = oh;
        out_ready = rdy;
        err_clr   = clr;
        @(posedge clk);
        acc   = v && (m_q.size() != DEPTH);
        legal = ($countones(oh) == 1);
        idx   = 0;
        for (int i = 0; i < N; i++) if (oh[i]) idx = i;
        if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (acc && legal) m_q.push_back(idx);
        if (acc && !legal) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        if (clr) m_err_cnt = (acc && !legal) ? 1 : 0;
        else if (acc && !legal && m_err_cnt < 255) m_err_cnt++;
        @(negedge clk);
    endtask

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", int'(in_ready), int'(m_q.size() != DEPTH));
            chk("out_valid", int'(out_valid), int'(m_q.size() != 0));
            chk("count", int'(count), m_q.size());
            if (m_q.size() != 0) chk("out_idx", int'(out_idx), m_q[0]);
            chk("err", int'(err), int'(m_err));
`ifdef ONEHOT_INDEX_QUEUE_ERR_CNT_EN
            chk("err_cnt", int'(err_cnt), m_err_cnt);
`endif
        end
    end

    initial begin
        int exp_seq[4];
        logic [N-1:0] rot;
        exp_seq = '{0, 2, 3, 1};
        rst_n = 1'b0; in_valid = 1'b0; in_onehot = '0; out_ready = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_count", int'(count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_err", int'(err), 0);
        chk_en = 1'b1;

        // Reset asserted mid-cycle with two entries queued
        step(1'b1, 4'b0010, 1'b0, 1'b0);
        step(1'b1, 4'b1000, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        chk("pre_rst_count", int'(count), 2);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_count", int'(count), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_err", int'(err), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Ordered fill then drain
        step(1'b1, 4'b0001, 1'b0, 1'b0);
        step(1'b1, 4'b0100, 1'b0, 1'b0);
        step(1'b1, 4'b1000, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 1'b0, 1'b0);
        chk("full_count", int'(count), 4);
        chk("full_in_ready", int'(in_ready), 0);
        for (int k = 0; k < 4; k++) begin
            chk("drain_idx", int'(out_idx), exp_seq[k]);
            chk("drain_count", int'(count), 4 - k);
            step(1'b0, 4'b0000, 1'b1, 1'b0);
        end
        chk("drained_count", int'(count), 0);

        // Empty pop ignored; push+pop on empty only pushes
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        step(1'b1, 4'b0100, 1'b1, 1'b0);
        chk("empty_pushpop_count", int'(count), 1);
        chk("empty_pushpop_idx", int'(out_idx), 2);
        step(1'b0, 4'b0000, 1'b1, 1'b0);

        // Illegal vectors, inputs ignored without in_valid, then clear
        step(1'b0, 4'b0110, 1'b0, 1'b0);
        chk("ignored_err", int'(err), 0);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b0110, 1'b0, 1'b0);
        chk("illegal_err", int'(err), 1);
        chk("illegal_count", int'(count), 0);
`ifdef ONEHOT_INDEX_QUEUE_ERR_CNT_EN
        chk("illegal_err_cnt", int'(err_cnt), 2);
`endif
        step(1'b0, 4'b0000, 1'b0, 1'b1);
        chk("clr_err", int'(err), 0);
`ifdef ONEHOT_INDEX_QUEUE_ERR_CNT_EN
        chk("clr_err_cnt", int'(err_cnt), 0);
`endif
        step(1'b1, 4'b1111, 1'b0, 1'b1);
        chk("clr_vs_set_err", int'(err), 1);
        step(1'b0, 4'b0000, 1'b0, 1'b1);

        // Full with simultaneous pop: pop only, then push+pop
        for (int k = 0; k < 4; k++) step(1'b1, 4'b0001 << k, 1'b0, 1'b0);
        step(1'b1, 4'b0001, 1'b1, 1'b0);
        chk("full_pop_count", int'(count), 3);
        chk("full_pop_in_ready", int'(in_ready), 1);
        step(1'b1, 4'b0001, 1'b1, 1'b0);
        chk("after_full_count", int'(count), 3);

        // Drain, then stream with one entry resident
        for (int k = 0; k < 3; k++) step(1'b0, 4'b0000, 1'b1, 1'b0);
        step(1'b1, 4'b1000, 1'b0, 1'b0);
        rot = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, rot, 1'b1, 1'b0);
            rot = {rot[N-2:0], rot[N-1]};
        end
        chk("stream_count", int'(count), 1);
        chk("stream_last_idx", int'(out_idx), 1);

`ifdef ONEHOT_INDEX_QUEUE_ERR_CNT_EN
        // Counter saturation, then clear racing an illegal accept
        for (int k = 0; k < 300; k++) step(1'b1, 4'b0011, 1'b0, 1'b0);
        chk("sat_err_cnt", int'(err_cnt), 255);
        chk("sat_err", int'(err), 1);
        step(1'b1, 4'b0000, 1'b0, 1'b1);
        chk("sat_clr_err_cnt", int'(err_cnt), 1);
        chk("sat_clr_err", int'(err), 1);
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/onehot_index_queue.md
Name: onehot_index_queue

Overview:
- Receive end of the 4-bit priority-encoder path: consumes one-hot grant vectors, checks that exactly one bit is set, and converts each legal vector to a binary index.
- Legal indices are buffered in a small FIFO and drained through a valid/ready handshake.
- Illegal vectors (all-zero or multi-hot) are consumed, dropped and flagged.
- Sits between the encoder output register and any downstream consumer that needs the granted line number.

Parameters:
- N, 4, one-hot input width; N >= 2.
- IDX_W, 2, index width; must equal ceil(log2(N)).
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  in_onehot is presented.
- in_onehot  input  N  grant vector; bit i set means line i.
- in_ready  output  1  block can accept this cycle.
- out_valid  output  1  out_idx holds the FIFO head.
- out_idx  output  IDX_W  binary index of the FIFO head.
- out_ready  input  1  consumer takes the head this cycle.
- count  output  IDX_W+1  FIFO occupancy, 0..DEPTH.
- err  output  1  sticky illegal-vector flag.
- err_clr  input  1  synchronous clear of err.

Behaviour:
- Reset (async assert, sync use after deassert) sets: in_ready=1, out_valid=0, out_idx=0, count=0, err=0. FIFO pointers go to 0 and FIFO contents are discarded. Reset mid-stream drops all queued entries.
- in_ready = (count != DEPTH). This is registered-state combinational and never depends on out_ready, so there is no pass-through path.
- Accept: in_valid & in_ready at a rising edge.
- Legal vector (popcount == 1): index i of the set bit is written at the tail and count increments. For example, 4'b0100 -> 2 and 4'b1000 -> 3.
- Illegal vector (popcount 0 or >= 2):
  - Consumed (the handshake completes) but not written; count is unchanged.
  - err <= 1 on the same edge.
- Pop: out_valid & out_ready at an edge; the head advances and count decrements.
- out_valid = (count != 0). out_idx = head entry. Both are stable while out_valid=1 and out_ready=0.
- Latency: a legal vector accepted at edge k is visible on out_valid/out_idx after edge k, i.e. 1 cycle when the FIFO was empty. There is no combinational in-to-out bypass.
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged, and both pointers advance modulo DEPTH.
- Full: in_ready=0, so no push is accepted even if a pop occurs in the same cycle. in_ready rises the cycle after the pop.
- Empty: out_ready is ignored and there is no underflow; count stays 0.
- Simultaneous push, pop and empty: out_valid stays 0 that cycle; the new entry appears next cycle.
- Pointers: IDX-sized wrap counters, log2(DEPTH) bits, wrapping DEPTH-1 -> 0. count is maintained separately to disambiguate full from empty.
- err_clr: clears err. If an illegal accept occurs in the same cycle, set wins and err=1.
- in_onehot is ignored when in_valid=0, and no err is raised.

Optional Feature:
- Macro ONEHOT_INDEX_QUEUE_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt [7:0], which counts illegal accepts and saturates at 255.
  - err_cnt resets to 0 and is cleared by err_clr.
  - If err_clr and an illegal accept occur in the same cycle, err_cnt=1.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Reset with queue non-empty: push 4'b0010 and 4'b1000, assert rst_n=0 mid-cycle -> outputs go immediately to count=0, out_valid=0, err=0, in_ready=1.
- Ordered drain: push 4'b0001, 4'b0100, 4'b1000, 4'b0010 with out_ready=0 -> count=4, in_ready=0. Then out_ready=1 -> out_idx sequence 0,2,3,1, with count decrementing 4->0.
- Illegal vectors: push 4'b0000 then 4'b0110 -> both accepted (in_ready=1), count stays 0, err=1. err_clr=1 for one cycle -> err=0. With the macro defined, err_cnt=2 before the clear and 0 after.
- Full with simultaneous pop: fill to 4, then in_valid=1 (4'b0001) with out_ready=1 -> pop only, count=3. Next cycle the push is accepted and count stays 3.
- Steady streaming: count=1, in_valid=1 and out_ready=1 every cycle for 10 cycles with rotating one-hot input -> count holds 1 and out_idx follows input with 1-entry lag.
- Saturation (macro defined): 300 illegal accepts -> err_cnt=255, err=1. Then err_clr with a simultaneous illegal accept -> err_cnt=1, err=1.
